// File: rtl/pwr_cntr_arb.sv
// Round-robin arbiter that turns per-requester increment pulses into read-modify-write
// cycles on a single counter-memory port, with a host read path that takes priority.
module pwr_cntr_arb #(
    parameter int NREQ = 4,
    parameter int NDIR = 1,
    parameter int DW   = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*(NDIR+1)-1:0] req_dir,
    output logic [NREQ-1:0]          ovf,
    input  logic                     host_rd,
    input  logic [NDIR:0]            host_dir,
    output logic                     host_busy,
    output logic                     host_vld,
    output logic [DW-1:0]            host_data,
    output logic [NDIR:0]            dir,
    output logic                     LE,
    inout  wire  [DW-1:0]            dato
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, HRD} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] ovf_q, ovf_d;
    logic [NDIR:0]   pendDir_q [NREQ];
    logic [NDIR:0]   pendDir_d [NREQ];
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]   nextGnt, idx;
    logic            found;
    logic            hostBusy_q, hostBusy_d;
    logic [NDIR:0]   hostDir_q, hostDir_d;
    logic            hostVld_q, hostVld_d;
    logic [DW-1:0]   hostData_q, hostData_d;
    logic [NDIR:0]   dir_q, dir_d;
    logic            le_q, le_d;
    logic [DW-1:0]   rdat_q, rdat_d;

    // A request arriving in the WR cycle that retires its own requester re-arms it.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NREQ; i++) begin
            pendDir_d[i] = pendDir_q[i];
            if (state_q == WR && gnt_q == PW'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (req[i]) begin
                if (!pend_d[i]) begin
                    pend_d[i]    = 1'b1;
                    pendDir_d[i] = req_dir[i*(NDIR+1) +: NDIR+1];
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        nextGnt = rr_q;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_q) + k) % NREQ);
            if (!found && pend_q[idx]) begin
                found   = 1'b1;
                nextGnt = idx;
            end
        end
    end

    // dir and LE are computed one state ahead so the port only changes on clock edges.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        le_d       = 1'b1;
        rdat_d     = rdat_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        hostBusy_d = hostBusy_q;
        hostDir_d  = hostDir_q;
        hostVld_d  = 1'b0;
        hostData_d = hostData_q;

        if (host_rd && !hostBusy_q) begin
            hostBusy_d = 1'b1;
            hostDir_d  = host_dir;
        end

        case (state_q)
            IDLE: begin
                if (hostBusy_q) begin
                    state_d = HRD;
                    dir_d   = hostDir_q;
                end else if (found) begin
                    state_d = RD;
                    gnt_d   = nextGnt;
                    dir_d   = pendDir_q[nextGnt];
                end
            end
            RD: begin
                rdat_d  = dato;
                le_d    = 1'b0;
                state_d = WR;
            end
            WR: begin
                rr_d    = (gnt_q == PW'(NREQ-1)) ? '0 : gnt_q + PW'(1);
                state_d = IDLE;
            end
            HRD: begin
                hostData_d = dato;
                hostVld_d  = 1'b1;
                hostBusy_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                pendDir_q[i] <= '0;
            end
            rr_q       <= '0;
            gnt_q      <= '0;
            hostBusy_q <= 1'b0;
            hostDir_q  <= '0;
            hostVld_q  <= 1'b0;
            hostData_q <= '0;
            dir_q      <= '0;
            le_q       <= 1'b1;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < NREQ; i++) begin
                pendDir_q[i] <= pendDir_d[i];
            end
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            hostBusy_q <= hostBusy_d;
            hostDir_q  <= hostDir_d;
            hostVld_q  <= hostVld_d;
            hostData_q <= hostData_d;
            dir_q      <= dir_d;
            le_q       <= le_d;
            rdat_q     <= rdat_d;
        end
    end

    assign ovf       = ovf_q;
    assign host_busy = hostBusy_q;
    assign host_vld  = hostVld_q;
    assign host_data = hostData_q;
    assign dir       = dir_q;
    assign LE        = le_q;
    assign dato      = le_q ? {DW{1'bz}} : rdat_q + DW'(1);

endmodule
